// File: rtl/cmp_slice_sequencer.sv
// Feeds two WIDTH-bit operands to one external 3-bit cascadable comparator slice, LSB slice first.
// Define SIGNED_CMP_EN to compare operands as two's complement.
module cmp_slice_sequencer #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [2:0]       slice_a,
  output logic [2:0]       slice_b,
  output logic             casc_l,
  output logic             casc_e,
  output logic             casc_g,
  input  logic             cmp_lt,
  input  logic             cmp_eq,
  input  logic             cmp_gt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             res_lt,
  output logic             res_eq,
  output logic             res_gt,
  output logic             res_err
);

  localparam int unsigned SLICES = WIDTH / 3;
  localparam int unsigned NUM_IDX = 2 ** CNT_W;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(SLICES - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic             cl_q, cl_d;
  logic             ce_q, ce_d;
  logic             cg_q, cg_d;
  logic             rl_q, rl_d;
  logic             re_q, re_d;
  logic             rg_q, rg_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] cap_a, cap_b;
  logic             cmp_onehot;
  logic             in_run;

  // Offset-binary mapping: flipping both MSBs turns signed order into unsigned order.
`ifdef SIGNED_CMP_EN
  assign cap_a = {~in_a[WIDTH-1], in_a[WIDTH-2:0]};
  assign cap_b = {~in_b[WIDTH-1], in_b[WIDTH-2:0]};
`else
  assign cap_a = in_a;
  assign cap_b = in_b;
`endif

  // Slice table padded to the full counter range so the index needs no width fix-up.
  logic [2:0] a_sl [NUM_IDX];
  logic [2:0] b_sl [NUM_IDX];

  for (genvar i = 0; i < NUM_IDX; i++) begin : g_slice
    if (i < SLICES) begin : g_used
      assign a_sl[i] = op_a_q[3*i +: 3];
      assign b_sl[i] = op_b_q[3*i +: 3];
    end else begin : g_pad
      assign a_sl[i] = 3'b000;
      assign b_sl[i] = 3'b000;
    end
  end

  // Exactly one of three: odd population count, but not all three.
  assign cmp_onehot = (cmp_lt ^ cmp_eq ^ cmp_gt) & ~(cmp_lt & cmp_eq & cmp_gt);
  assign in_run     = (state_q == RUN);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    cl_d    = cl_q;
    ce_d    = ce_q;
    cg_d    = cg_q;
    rl_d    = rl_q;
    re_d    = re_q;
    rg_d    = rg_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = RUN;
          idx_d   = '0;
          op_a_d  = cap_a;
          op_b_d  = cap_b;
          cl_d    = 1'b0;
          ce_d    = 1'b1;
          cg_d    = 1'b0;
          err_d   = 1'b0;
        end
      end
      RUN: begin
        cl_d  = cmp_lt;
        ce_d  = cmp_eq;
        cg_d  = cmp_gt;
        err_d = err_q | ~cmp_onehot;
        idx_d = idx_q + CNT_W'(1);
        if (idx_q == LAST_IDX) begin
          rl_d    = cmp_lt;
          re_d    = cmp_eq;
          rg_d    = cmp_gt;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      cl_q    <= 1'b0;
      ce_q    <= 1'b1;
      cg_q    <= 1'b0;
      rl_q    <= 1'b0;
      re_q    <= 1'b0;
      rg_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      cl_q    <= cl_d;
      ce_q    <= ce_d;
      cg_q    <= cg_d;
      rl_q    <= rl_d;
      re_q    <= re_d;
      rg_q    <= rg_d;
      err_q   <= err_d;
    end
  end

  // Outside RUN the comparator is parked at a neutral "equal" input.
  always_comb begin
    slice_a = 3'b000;
    slice_b = 3'b000;
    casc_l  = 1'b0;
    casc_e  = 1'b1;
    casc_g  = 1'b0;
    if (in_run) begin
      slice_a = a_sl[idx_q];
      slice_b = b_sl[idx_q];
      casc_l  = cl_q;
      casc_e  = ce_q;
      casc_g  = cg_q;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign res_lt    = rl_q;
  assign res_eq    = re_q;
  assign res_gt    = rg_q;
  assign res_err   = err_q;

endmodule

// File: tb/tb_cmp_slice_sequencer.sv
// Self-checking bench for cmp_slice_sequencer with a behavioural 3-bit comparator slice.
module tb_cmp_slice_sequencer;

  localparam int unsigned WIDTH  = 12;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned SLICES = WIDTH / 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic [2:0]       slice_a, slice_b;
  logic             casc_l, casc_e, casc_g;
  logic             cmp_lt, cmp_eq, cmp_gt;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic             res_lt, res_eq, res_gt, res_err;
  logic             force_bad = 1'b0;

  typedef struct {
    logic [2:0] leg;
    logic       err;
    bit         chk_res;
  } exp_t;

  exp_t       sb[$];
  int         compared = 0;
  int         mismatched = 0;
  logic [2:0] seq [SLICES];

  cmp_slice_sequencer #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .slice_a  (slice_a),
    .slice_b  (slice_b),
    .casc_l   (casc_l),
    .casc_e   (casc_e),
    .casc_g   (casc_g),
    .cmp_lt   (cmp_lt),
    .cmp_eq   (cmp_eq),
    .cmp_gt   (cmp_gt),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .res_lt   (res_lt),
    .res_eq   (res_eq),
    .res_gt   (res_gt),
    .res_err  (res_err)
  );

  always #5 clk = ~clk;

  // Comparator slice model; force_bad makes it emit an illegal lt=gt=1.
  always_comb begin
    if (force_bad)              {cmp_lt, cmp_eq, cmp_gt} = 3'b101;
    else if (slice_a > slice_b) {cmp_lt, cmp_eq, cmp_gt} = 3'b001;
    else if (slice_a < slice_b) {cmp_lt, cmp_eq, cmp_gt} = 3'b100;
    else                        {cmp_lt, cmp_eq, cmp_gt} = {casc_l, casc_e, casc_g};
  end

  function automatic logic [2:0] ref_cmp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef SIGNED_CMP_EN
    if ($signed(a) < $signed(b)) return 3'b100;
    if ($signed(a) > $signed(b)) return 3'b001;
`else
    if (a < b) return 3'b100;
    if (a > b) return 3'b001;
`endif
    return 3'b010;
  endfunction

  function automatic logic [WIDTH-1:0] mapped(input logic [WIDTH-1:0] a);
`ifdef SIGNED_CMP_EN
    return a ^ {1'b1, {(WIDTH-1){1'b0}}};
`else
    return a;
`endif
  endfunction

  // One complete operation; hold > 0 keeps out_ready low that many cycles in DONE.
  task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input int hold, input bit inject);
    exp_t e;
    int   lat;
    e.leg     = ref_cmp(a, b);
    e.err     = inject;
    e.chk_res = !inject;
    out_ready = (hold == 0);
    @(negedge clk);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    compared++;
    if (in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL in_ready_idle: got %b want 1", in_ready);
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    seq[0] = slice_a;
    while (out_valid !== 1'b1 && lat < 3 * SLICES) begin
      @(posedge clk);
      #1;
      lat++;
      if (inject) force_bad = (lat == 1);
      if (lat < SLICES) seq[lat] = slice_a;
    end
    force_bad = 1'b0;
    compared++;
    if (lat != SLICES) begin
      mismatched++;
      $display("FAIL latency: got %0d edges want %0d", lat, SLICES);
    end
    e = sb.pop_front();
    if (out_valid !== 1'b1) begin
      out_ready = 1'b1;
      return;
    end
    compared++;
    if (res_err !== e.err) begin
      mismatched++;
      $display("FAIL res_err: got %b want %b (a=%h b=%h)", res_err, e.err, a, b);
    end
    if (e.chk_res) begin
      compared++;
      if ({res_lt, res_eq, res_gt} !== e.leg) begin
        mismatched++;
        $display("FAIL result lt/eq/gt: got %b want %b (a=%h b=%h)",
                 {res_lt, res_eq, res_gt}, e.leg, a, b);
      end
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_a     = ~a;
      in_b     = b;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      compared++;
      if ({out_valid, in_ready, res_lt, res_eq, res_gt, res_err} !== {2'b10, e.leg, e.err}) begin
        mismatched++;
        $display("FAIL hold cycle %0d: got %b want %b", i,
                 {out_valid, in_ready, res_lt, res_eq, res_gt, res_err}, {2'b10, e.leg, e.err});
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    compared++;
    if ({out_valid, in_ready} !== 2'b01) begin
      mismatched++;
      $display("FAIL release: got out_valid/in_ready %b want 01", {out_valid, in_ready});
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    compared++;
    if ({in_ready, out_valid, res_lt, res_eq, res_gt, res_err, casc_l, casc_e, casc_g,
         slice_a, slice_b} !== {2'b10, 4'b0000, 3'b010, 6'b0}) begin
      mismatched++;
      $display("FAIL reset_state: got %b", {in_ready, out_valid, res_lt, res_eq, res_gt,
               res_err, casc_l, casc_e, casc_g, slice_a, slice_b});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    do_op(12'h5A3, 12'h5A3, 0, 1'b0);
    do_op(12'h001, 12'h002, 0, 1'b0);
    do_op(12'h400, 12'h3FF, 0, 1'b0);
  endtask

  task automatic test_slices();
    logic [WIDTH-1:0] m;
    do_op(12'h003, 12'h000, 0, 1'b0);
    m = mapped(12'h003);
    for (int i = 0; i < SLICES; i++) begin
      compared++;
      if (seq[i] !== m[3*i +: 3]) begin
        mismatched++;
        $display("FAIL slice_a[%0d]: got %0d want %0d", i, seq[i], m[3*i +: 3]);
      end
    end
  endtask

  task automatic test_sign();
    do_op(12'h800, 12'h7FF, 0, 1'b0);
  endtask

  task automatic test_hold();
    do_op(12'h0F0, 12'h0F1, 10, 1'b0);
  endtask

  task automatic test_reset_mid_run();
    int bad;
    @(negedge clk);
    in_valid = 1'b1;
    in_a     = 12'h0F8;
    in_b     = 12'h000;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    compared++;
    if ({in_ready, out_valid, res_lt, res_eq, res_gt, res_err, casc_l, casc_e, casc_g,
         slice_a, slice_b} !== {2'b10, 4'b0000, 3'b010, 6'b0}) begin
      mismatched++;
      $display("FAIL mid_run_reset: got %b", {in_ready, out_valid, res_lt, res_eq, res_gt,
               res_err, casc_l, casc_e, casc_g, slice_a, slice_b});
    end
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b0) bad++;
    end
    compared++;
    if (bad != 0) begin
      mismatched++;
      $display("FAIL no_pulse_after_reset: got %0d out_valid cycles want 0", bad);
    end
    do_op(12'h123, 12'h124, 0, 1'b0);
  endtask

  task automatic test_err();
    do_op(12'h2A5, 12'h2A5, 0, 1'b1);
    do_op(12'h010, 12'h010, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      do_op(WIDTH'($urandom), WIDTH'($urandom), 0, 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_slices();
    test_sign();
    test_hold();
    test_reset_mid_run();
    test_err();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
